// File: rtl/mem_block_copy_pkg.sv
// mem_block_copy_pkg: shared state encodings and default sizes for the block-copy initiator
package mem_block_copy_pkg;

    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_DATA_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_block_copy.sv
// mem_block_copy: ascending word-by-word copy inside the data memory; optional checksum output via MEM_BLOCK_COPY_CHECKSUM_EN
module mem_block_copy
    import mem_block_copy_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] src_addr,
    input  logic [ADDR_SIZE-1:0] dst_addr,
    input  logic [ADDR_SIZE:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic                 mem_memread,
    output logic                 mem_memwrite,
    input  logic [DATA_SIZE-1:0] mem_rdata
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
    ,
    output logic [DATA_SIZE-1:0] checksum
`endif
);

    state_t                 state, state_nxt;
    logic [ADDR_SIZE-1:0]   src_ptr, dst_ptr;
    logic [ADDR_SIZE:0]     remaining;
    logic [DATA_SIZE-1:0]   data_reg;
    logic                   accept;

    assign accept = (state == IDLE) && start;

    // state register, operand latch, read capture and per-word pointer advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_reg  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                src_ptr   <= src_addr;
                dst_ptr   <= dst_addr;
                remaining <= len;
            end
            if (state == READ)
                data_reg <= mem_rdata;
            if (state == WRITE) begin
                src_ptr   <= src_ptr + ADDR_SIZE'(1);
                dst_ptr   <= dst_ptr + ADDR_SIZE'(1);
                remaining <= remaining - (ADDR_SIZE+1)'(1);
            end
        end
    end

    // next state and Moore memory controls; only one enable per state so they never overlap
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        case (state)
            IDLE: state_nxt = start ? ((len == '0) ? DONE : READ) : IDLE;
            READ: begin
                state_nxt   = WRITE;
                busy        = 1'b1;
                mem_addr    = src_ptr;
                mem_memread = 1'b1;
            end
            WRITE: begin
                state_nxt    = (remaining == (ADDR_SIZE+1)'(1)) ? DONE : READ;
                busy         = 1'b1;
                mem_addr     = dst_ptr;
                mem_wdata    = data_reg;
                mem_memwrite = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
        endcase
    end

`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
    // running sum of every word written; held after done until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (state == WRITE)
            checksum <= checksum + data_reg;
    end
`endif

endmodule
